// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory-stage data responder: FSM encoding and lane/offset constants.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int BYTE_LANES         = DATA_WIDTH_DEFAULT / 8;
    localparam int WORD_OFFSET_W      = 2;

    function automatic int lanes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH x DATA_WIDTH word storage built from one byte-wide RAM per lane,
// each with its own write enable and a registered read port.
module dmem_byte_array
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int INDEX_W    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic [DATA_WIDTH/8-1:0] lane_we,
    input  logic                    rd_en,
    input  logic [INDEX_W-1:0]      index,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = lanes_of(DATA_WIDTH);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_reg;

            // Contents are deliberately never reset so the array maps onto block RAM.
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[index] <= wdata[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_reg <= lane_mem[index];
                end
            end

            assign rdata[gi*8 +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: accepts one load/store, waits LATENCY
// cycles, commits the access and pulses a one-cycle response; stalls the pipeline meanwhile.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 256,
    parameter int LATENCY       = 2
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_ReqValidM,
    input  logic                     i_MemWriteM,
    input  logic [DATA_WIDTH/8-1:0]  i_ByteEnM,
    input  logic [ADDRESS_WIDTH-1:0] i_AddrM,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
    output logic                     o_ReqReadyM,
    output logic                     o_RespValidM,
    output logic [DATA_WIDTH-1:0]    o_ReadDataM,
    output logic                     o_ErrM,
    output logic                     o_StallM
);

    localparam int LANES   = lanes_of(DATA_WIDTH);
    localparam int INDEX_W = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(LATENCY + 1);

    mem_state_t state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     we_reg;
    logic [LANES-1:0]         be_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0]    wdata_reg;

    logic                  accept;
    logic                  fault;
    logic                  commit;
    logic [LANES-1:0]      lane_we;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rdata;

    assign accept = (state_reg == IDLE) & i_ReqValidM & ~i_RST;

    // Misaligned or out-of-range accesses never touch storage, so the word index cannot wrap.
    assign fault = (addr_reg[WORD_OFFSET_W-1:0] != '0) |
                   ({{WORD_OFFSET_W{1'b0}}, addr_reg[ADDRESS_WIDTH-1:WORD_OFFSET_W]}
                    >= ADDRESS_WIDTH'(DEPTH));

    assign commit  = (state_reg == WAIT) & (cnt_reg == '0);
    assign lane_we = (commit & we_reg & ~fault) ? be_reg : '0;
    assign rd_en   = commit & ~we_reg & ~fault;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            be_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg   <= CNT_W'(LATENCY - 1);
                we_reg    <= i_MemWriteM;
                be_reg    <= i_ByteEnM;
                addr_reg  <= i_AddrM;
                wdata_reg <= i_WriteDataM;
            end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_ReqValidM) state_next = WAIT;
            WAIT:    if (cnt_reg == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    dmem_byte_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INDEX_W    (INDEX_W)
    ) u_array (
        .clk     (i_CLK),
        .lane_we (lane_we),
        .rd_en   (rd_en),
        .index   (addr_reg[WORD_OFFSET_W +: INDEX_W]),
        .wdata   (wdata_reg),
        .rdata   (rdata)
    );

    assign o_ReqReadyM  = (state_reg == IDLE) & ~i_RST;
    assign o_RespValidM = (state_reg == RESP);
    assign o_ErrM       = (state_reg == RESP) & fault;
    assign o_ReadDataM  = ((state_reg == RESP) & ~we_reg & ~fault) ? rdata : '0;
    assign o_StallM     = ~i_RST & (((state_reg == IDLE) & i_ReqValidM) | (state_reg == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// multi-cycle sequences, and randomized accesses against a word-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        mem_write;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
    logic        err;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .DEPTH         (DEPTH),
        .LATENCY       (LATENCY)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_ReqValidM  (valid),
        .i_MemWriteM  (mem_write),
        .i_ByteEnM    (be),
        .i_AddrM      (addr),
        .i_WriteDataM (wdata),
        .o_ReqReadyM  (ready),
        .o_RespValidM (resp),
        .o_ReadDataM  (rdata),
        .o_ErrM       (err),
        .o_StallM     (stall)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: a flat word array, faults by alignment/range, byte-lane merge on store.
    task automatic model_apply(input logic w, input logic [3:0] lanes, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] exp_rd,
                               output logic exp_err, output bit known);
        int unsigned idx;
        exp_err = ((a % 4) != 0) || ((a / 4) >= DEPTH);
        exp_rd  = '0;
        known   = 1'b1;
        if (!exp_err) begin
            idx = a / 4;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (lanes[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
                if (lanes == 4'hF) model_known[idx] = 1'b1;
            end else begin
                exp_rd = model_mem[idx];
                known  = model_known[idx];
            end
        end
    endtask

    // Full handshake from IDLE; checks ready/stall/latency and one-cycle response.
    task automatic run_access(input logic w, input logic [3:0] lanes, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] rd, output logic er);
        int cyc;
        bit got;
        valid = 1'b1; mem_write = w; be = lanes; addr = a; wdata = d;
        #1;
        check("ready_idle", ready, 1);
        check("stall_accept", stall, 1);
        cyc = 0; got = 0; rd = '0; er = 1'b0;
        while (!got && cyc < 12) begin
            cycle();
            cyc++;
            valid = 1'b0;
            #1;
            if (resp) begin
                got = 1;
                rd  = rdata;
                er  = err;
                check("stall_resp", stall, 0);
                check("ready_resp", ready, 0);
            end else begin
                check("stall_wait", stall, 1);
                check("ready_wait", ready, 0);
            end
        end
        check("resp_seen", got, 1);
        check("latency", cyc, LATENCY + 1);
        cycle();
        #1;
        check("resp_pulse", resp, 0);
        $display("txn we=%0d be=%h addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 w, lanes, a, d, rd, er, cyc);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rd, exp_rd, pre20, rnd_addr;
        logic        er, exp_err, w;
        logic [3:0]  lanes;
        bit          known;
        int          kind;

        vecs[0] = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[1] = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[2] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 32'h0,         1'b0};
        vecs[4] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
        vecs[5] = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
        vecs[7] = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'h0,         1'b1};
        vecs[8] = '{1'b1, 4'hF, 32'h0000_0400, 32'h0000_0055, 32'h0,         1'b1};
        vecs[9] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};

        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

        // Reset state, with valid asserted to show outputs stay quiet during reset.
        rst = 1'b1; valid = 1'b1; mem_write = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        #12;
        check("rst_ready", ready, 0);
        check("rst_resp", resp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post_rst_ready", ready, 1);

        // Preload words 0..63 so every later load has a known expectation.
        for (int i = 0; i < 64; i++) begin
            w = 1'b1; rnd_addr = 32'(i * 4); wdata = $urandom;
            model_apply(1'b1, 4'hF, rnd_addr, wdata, exp_rd, exp_err, known);
            run_access(1'b1, 4'hF, rnd_addr, wdata, rd, er);
            check("fill_err", er, 0);
        end

        for (int i = 0; i < 10; i++) begin
            model_apply(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, exp_rd, exp_err, known);
            run_access(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
        end

        // Inputs toggled during WAIT must not affect the latched store.
        valid = 1'b1; mem_write = 1'b1; be = 4'hF; addr = 32'h30; wdata = 32'h1111_2222;
        model_apply(1'b1, 4'hF, 32'h30, 32'h1111_2222, exp_rd, exp_err, known);
        cycle();
        for (int c = 1; c <= LATENCY + 1; c++) begin
            addr = 32'h34; wdata = $urandom; be = 4'($urandom); mem_write = ~mem_write;
            #1;
            check("toggle_ready", ready, 0);
            check("toggle_resp", resp, (c == LATENCY + 1) ? 1 : 0);
            if (c == LATENCY + 1) valid = 1'b0;
            cycle();
        end
        $display("txn toggled-store addr=00000030 wdata=11112222");
        model_apply(1'b0, 4'hF, 32'h30, 32'h0, exp_rd, exp_err, known);
        run_access(1'b0, 4'hF, 32'h30, 32'h0, rd, er);
        check("toggle_commit", rd, exp_rd);
        model_apply(1'b0, 4'hF, 32'h34, 32'h0, exp_rd, exp_err, known);
        run_access(1'b0, 4'hF, 32'h34, 32'h0, rd, er);
        check("toggle_neighbor", rd, exp_rd);

        // Valid held through RESP: back-to-back accesses every LATENCY+2 cycles.
        valid = 1'b1; mem_write = 1'b0; be = 4'hF; addr = 32'h10; wdata = '0;
        #1;
        check("hold_ready0", ready, 1);
        for (int c = 1; c <= 2 * (LATENCY + 2); c++) begin
            cycle();
            check($sformatf("hold_resp_c%0d", c), resp,
                  ((c % (LATENCY + 2)) == LATENCY + 1) ? 1 : 0);
            check($sformatf("hold_ready_c%0d", c), ready,
                  ((c % (LATENCY + 2)) == 0) ? 1 : 0);
            if (resp) check("hold_rdata", rdata, 32'hDEAD_AAEF);
            if (c == 2 * (LATENCY + 2)) valid = 1'b0;
        end
        $display("txn held-valid load addr=00000010 x2");
        cycle();

        // Reset during WAIT abandons the store.
        model_apply(1'b0, 4'hF, 32'h20, 32'h0, pre20, exp_err, known);
        valid = 1'b1; mem_write = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h1234_5678;
        cycle();
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", ready, 0);
        check("midrst_resp", resp, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_err", err, 0);
        check("midrst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("midrst_idle", ready, 1);
        $display("txn reset-abandoned store addr=00000020");
        run_access(1'b0, 4'hF, 32'h20, 32'h0, rd, er);
        check("midrst_nocommit", rd, pre20);

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      rnd_addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (kind == 1) rnd_addr = 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
            else                rnd_addr = 32'($urandom_range(0, 63) * 4);
            w = 1'($urandom_range(0, 1));
            lanes = 4'($urandom);
            wdata = $urandom;
            model_apply(w, lanes, rnd_addr, wdata, exp_rd, exp_err, known);
            run_access(w, lanes, rnd_addr, wdata, rd, er);
            check("rand_err", er, exp_err);
            if (known) check("rand_rdata", rd, exp_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
